// File: rtl/mod_counter.sv
// Modulo-N up/down counter with parallel load, synchronous clear, wrap or
// saturate at the range limits, and terminal-count / wrap / overflow flags.
module mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit PARAM_OK = (WIDTH >= 2) && (WIDTH <= 32) &&
                            (MODULUS >= 64'd2) && (MODULUS <= (64'd1 << WIDTH));

  generate
    if (!PARAM_OK) begin : g_param_check
      $error("mod_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_limit;

  // The explicit limit compare also covers MODULUS == 2**WIDTH, so natural
  // rollover of the adder is never relied upon.
  assign at_limit = up ? (count_q == MAX_VAL) : (count_q == '0);
  assign tc       = en & at_limit;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (at_limit) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
        if (!SATURATE) begin
          count_d = up ? '0 : MAX_VAL;
        end
      end else begin
        count_d = up ? (count_q + ONE) : (count_q - ONE);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule
